// File: rtl/prco_exec_unit_if.sv
// prco_exec_unit_if: groups the request, program-load, register-file and result
// signals of the PRCO execute unit.
//   master : the core side (drives start/pc/program-load and register read data)
//   slave  : the execute unit (drives selects, writeback, done/busy, branch, flags)
// Signal names keep the unit's i_/q_ naming so they read the same from both sides.
interface prco_exec_unit_if #(
    parameter int unsigned MEM_AW = 8
);
    logic              i_start;
    logic [15:0]       i_pc;
    logic              i_ld_we;
    logic [MEM_AW-1:0] i_ld_addr;
    logic [15:0]       i_ld_data;
    logic [2:0]        q_sela;
    logic [2:0]        q_selb;
    logic [15:0]       i_rega;
    logic [15:0]       i_regb;
    logic              q_wb_en;
    logic [2:0]        q_wb_sel;
    logic [15:0]       q_wb_data;
    logic              q_done;
    logic              q_busy;
    logic              q_should_branch;
    logic [15:0]       q_next_pc;
    logic [2:0]        q_flags;

    modport master (
        output i_start, i_pc, i_ld_we, i_ld_addr, i_ld_data, i_rega, i_regb,
        input  q_sela, q_selb, q_wb_en, q_wb_sel, q_wb_data, q_done, q_busy,
               q_should_branch, q_next_pc, q_flags
    );

    modport slave (
        input  i_start, i_pc, i_ld_we, i_ld_addr, i_ld_data, i_rega, i_regb,
        output q_sela, q_selb, q_wb_en, q_wb_sel, q_wb_data, q_done, q_busy,
               q_should_branch, q_next_pc, q_flags
    );
endinterface

// File: rtl/prco_exec_unit.sv
// prco_exec_unit: single-issue fetch/decode/execute/memory/writeback unit of the
// PRCO 16-bit CPU with a local 2^MEM_AW x 16 program/data memory.
// Ports:
//   i_clk   : clock, all state changes on the rising edge
//   i_reset : asynchronous active-high reset (memory contents are kept)
//   bus     : prco_exec_unit_if.slave
//             in : i_start, i_pc, i_ld_we/i_ld_addr/i_ld_data, i_rega, i_regb
//             out: q_sela/q_selb, q_wb_en/q_wb_sel/q_wb_data, q_done, q_busy,
//                  q_should_branch, q_next_pc, q_flags {N,C,Z}
module prco_exec_unit #(
    parameter int unsigned MEM_AW = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    prco_exec_unit_if.slave   bus
);

    localparam logic [4:0] OpMov   = 5'h01;
    localparam logic [4:0] OpMovi  = 5'h02;
    localparam logic [4:0] OpAdd   = 5'h03;
    localparam logic [4:0] OpSub   = 5'h04;
    localparam logic [4:0] OpAddi  = 5'h05;
    localparam logic [4:0] OpAnd   = 5'h06;
    localparam logic [4:0] OpOr    = 5'h07;
    localparam logic [4:0] OpXor   = 5'h08;
    localparam logic [4:0] OpShift = 5'h09;
    localparam logic [4:0] OpCmp   = 5'h0A;
    localparam logic [4:0] OpLw    = 5'h0B;
    localparam logic [4:0] OpSw    = 5'h0C;
    localparam logic [4:0] OpJmp   = 5'h0D;
    localparam logic [4:0] OpJeq   = 5'h0E;
    localparam logic [4:0] OpJne   = 5'h0F;
    localparam logic [4:0] OpJlt   = 5'h10;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb
    } state_e;

    state_e r_state, w_state_nxt;

    logic [15:0] r_mem [0:(1 << MEM_AW) - 1];
    logic [15:0] r_rdata;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_result;
    logic [15:0] r_store;
    logic [2:0]  r_cmp_flags;

    logic [2:0]  r_sela, r_selb;
    logic        r_wb_en, r_done, r_should_branch;
    logic [2:0]  r_wb_sel, r_flags;
    logic [15:0] r_wb_data, r_next_pc;

    // Decoded fields of the latched instruction
    logic [4:0]  w_op;
    logic [2:0]  w_d;
    logic [7:0]  w_imm8;
    logic [4:0]  w_simm5;
    // Fields of the word coming out of the memory during FETCH
    logic [4:0]  w_f_op;

    logic [15:0] w_alu;
    logic [15:0] w_ea;
    logic [2:0]  w_cmp;
    logic        w_is_mem, w_wb_en, w_taken;

    logic              w_we;
    logic [MEM_AW-1:0] w_waddr, w_raddr;
    logic [15:0]       w_wdata;

    assign w_op    = r_instr[15:11];
    assign w_d     = r_instr[10:8];
    assign w_imm8  = r_instr[7:0];
    assign w_simm5 = r_instr[4:0];
    assign w_f_op  = r_rdata[15:11];

    assign w_is_mem = (w_op == OpLw) || (w_op == OpSw);
    assign w_wb_en  = ((w_op >= OpMov) && (w_op <= OpShift)) || (w_op == OpLw);
    assign w_ea     = bus.i_regb + {{11{w_simm5[4]}}, w_simm5};

    // ---------------------------------------------------------------- memory
    // In MEM the port serves the load/store; otherwise it fetches at i_pc and
    // accepts program loads (IDLE only). Read-before-write on the same address.
    always_comb begin
        w_raddr = bus.i_pc[MEM_AW-1:0];
        w_waddr = bus.i_ld_addr;
        w_wdata = bus.i_ld_data;
        w_we    = (r_state == StIdle) && bus.i_ld_we;
        if (r_state == StMem) begin
            w_raddr = r_result[MEM_AW-1:0];
            w_waddr = r_result[MEM_AW-1:0];
            w_wdata = r_store;
            w_we    = (w_op == OpSw);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rdata <= r_mem[w_raddr];
    end

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (bus.i_start) w_state_nxt = StFetch;
            StFetch:  w_state_nxt = StDecode;
            StDecode: w_state_nxt = StExec;
            StExec:   w_state_nxt = w_is_mem ? StMem : StWb;
            StMem:    w_state_nxt = StWb;
            StWb:     w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- ALU
    // "d" operand arrives on i_rega, "a" on i_regb; for CMP they are a and b.
    always_comb begin
        w_alu = 16'h0000;
        w_cmp = {($signed(bus.i_rega) < $signed(bus.i_regb)),
                 (bus.i_rega < bus.i_regb),
                 (bus.i_rega == bus.i_regb)};
        case (w_op)
            OpMov:   w_alu = bus.i_regb;
            OpMovi:  w_alu = {8'h00, w_imm8};
            OpAdd:   w_alu = bus.i_rega + bus.i_regb;
            OpSub:   w_alu = bus.i_rega - bus.i_regb;
            OpAddi:  w_alu = bus.i_rega + {8'h00, w_imm8};
            OpAnd:   w_alu = bus.i_rega & bus.i_regb;
            OpOr:    w_alu = bus.i_rega | bus.i_regb;
            OpXor:   w_alu = bus.i_rega ^ bus.i_regb;
            OpShift: w_alu = w_simm5[4] ? (bus.i_regb >> w_simm5[3:0])
                                        : (bus.i_regb << w_simm5[3:0]);
            OpLw,
            OpSw:    w_alu = w_ea;
            default: w_alu = 16'h0000;
        endcase
    end

    // Branches test the flags left by the most recent CMP
    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            OpJmp:   w_taken = 1'b1;
            OpJeq:   w_taken = r_flags[0];
            OpJne:   w_taken = ~r_flags[0];
            OpJlt:   w_taken = r_flags[2];
            default: w_taken = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= StIdle;
            r_pc            <= 16'h0000;
            r_instr         <= 16'h0000;
            r_result        <= 16'h0000;
            r_store         <= 16'h0000;
            r_cmp_flags     <= 3'b000;
            r_sela          <= 3'b000;
            r_selb          <= 3'b000;
            r_wb_en         <= 1'b0;
            r_done          <= 1'b0;
            r_wb_sel        <= 3'b000;
            r_wb_data       <= 16'h0000;
            r_should_branch <= 1'b0;
            r_next_pc       <= 16'h0000;
            r_flags         <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            r_wb_en <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.i_start) r_pc <= bus.i_pc;
                end
                StFetch: begin
                    r_instr <= r_rdata;
                    if (w_f_op == OpCmp) begin
                        r_sela <= r_rdata[7:5];
                        r_selb <= r_rdata[4:2];
                    end else begin
                        r_sela <= r_rdata[10:8];
                        r_selb <= r_rdata[7:5];
                    end
                end
                StExec: begin
                    r_result    <= w_alu;
                    r_store     <= bus.i_rega;
                    r_cmp_flags <= w_cmp;
                end
                StWb: begin
                    r_done          <= 1'b1;
                    r_wb_en         <= w_wb_en;
                    r_wb_sel        <= w_d;
                    r_wb_data       <= (w_op == OpLw) ? r_rdata : r_result;
                    r_should_branch <= w_taken;
                    r_next_pc       <= w_taken ? {8'h00, w_imm8} : (r_pc + 16'd1);
                    if (w_op == OpCmp) r_flags <= r_cmp_flags;
                end
                default: ;
            endcase
        end
    end

    assign bus.q_sela          = r_sela;
    assign bus.q_selb          = r_selb;
    assign bus.q_wb_en         = r_wb_en;
    assign bus.q_wb_sel        = r_wb_sel;
    assign bus.q_wb_data       = r_wb_data;
    assign bus.q_done          = r_done;
    assign bus.q_busy          = (r_state != StIdle);
    assign bus.q_should_branch = r_should_branch;
    assign bus.q_next_pc       = r_next_pc;
    assign bus.q_flags         = r_flags;

endmodule

// File: tb/tb_prco_exec_unit.sv
// Bench for prco_exec_unit: directed table of single instructions, hand-written
// multi-cycle sequences (load/store, reset abort, busy handshakes) and random
// instructions checked against an instruction-level reference model.
module tb_prco_exec_unit;
    localparam int unsigned MEM_AW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prco_exec_unit_if #(.MEM_AW(MEM_AW)) bus ();
    prco_exec_unit #(.MEM_AW(MEM_AW)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    // Register file model answering the unit's read selects
    logic [15:0] regs [8];
    assign bus.i_rega = regs[bus.q_sela];
    assign bus.i_regb = regs[bus.q_selb];

    logic [15:0] mdl_mem [256];
    logic [2:0]  mdl_flags;
    int checks = 0;
    int failures = 0;
    string cur_tag = "";

    typedef struct {
        logic        wb_en;
        logic [2:0]  wb_sel;
        logic [15:0] wb_data;
        logic        br;
        logic [15:0] npc;
        logic [2:0]  flags;
        logic [2:0]  sela;
        logic [2:0]  selb;
        int          lat;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] dv;
        logic [15:0] av;
        logic [15:0] bv;
        logic        wb_en;
        logic [15:0] data;
        logic        br;
        logic [15:0] npc;
        logic [2:0]  flags;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%s]: got %0h, expected %0h", name, cur_tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] addr, input logic [15:0] data);
        bus.i_ld_we   = 1'b1;
        bus.i_ld_addr = addr;
        bus.i_ld_data = data;
        tick();
        bus.i_ld_we   = 1'b0;
        mdl_mem[addr] = data;
    endtask

    // Instruction-level behaviour; updates model memory and flags.
    task automatic model(input logic [15:0] instr, input logic [15:0] pc, output exp_t e);
        logic [4:0]  op;
        logic [2:0]  d, a, b;
        logic [7:0]  imm8;
        logic [4:0]  s5;
        logic [15:0] dv, av, bv, ea;
        op = instr[15:11]; d = instr[10:8]; a = instr[7:5]; b = instr[4:2];
        imm8 = instr[7:0]; s5 = instr[4:0];
        dv = regs[d]; av = regs[a]; bv = regs[b];
        ea = av + {{11{s5[4]}}, s5};
        e.wb_data = 16'h0000; e.br = 1'b0; e.lat = 4; e.sela = d; e.selb = a; e.wb_sel = d;
        case (op)
            5'h01: e.wb_data = av;
            5'h02: e.wb_data = {8'h00, imm8};
            5'h03: e.wb_data = dv + av;
            5'h04: e.wb_data = dv - av;
            5'h05: e.wb_data = dv + {8'h00, imm8};
            5'h06: e.wb_data = dv & av;
            5'h07: e.wb_data = dv | av;
            5'h08: e.wb_data = dv ^ av;
            5'h09: e.wb_data = s5[4] ? (av >> s5[3:0]) : (av << s5[3:0]);
            5'h0A: begin
                e.sela = a; e.selb = b;
                mdl_flags = {($signed(av) < $signed(bv)), (av < bv), (av == bv)};
            end
            5'h0B: begin e.wb_data = mdl_mem[ea[7:0]]; e.lat = 5; end
            5'h0C: begin mdl_mem[ea[7:0]] = dv; e.lat = 5; end
            5'h0D: e.br = 1'b1;
            5'h0E: e.br = mdl_flags[0];
            5'h0F: e.br = !mdl_flags[0];
            5'h10: e.br = mdl_flags[2];
            default: ;
        endcase
        e.wb_en = ((op >= 5'h01) && (op <= 5'h09)) || (op == 5'h0B);
        e.npc   = e.br ? {8'h00, imm8} : pc + 16'd1;
        e.flags = mdl_flags;
    endtask

    // Starts the instruction stored at pc and checks the whole transaction.
    task automatic run(input logic [15:0] pc, input logic ld_en, input logic [7:0] ld_addr,
                       input logic [15:0] ld_data, input bit poke, input bit use_tbl,
                       input vec_t v);
        logic [15:0] instr;
        exp_t e;
        int n;
        bit seen;
        instr = mdl_mem[pc[7:0]];
        cur_tag = $sformatf("instr %h pc %h", instr, pc);
        if (ld_en) mdl_mem[ld_addr] = ld_data;
        model(instr, pc, e);
        if (use_tbl) begin
            e.wb_en = v.wb_en; e.wb_data = v.data; e.br = v.br; e.npc = v.npc; e.flags = v.flags;
        end
        bus.i_pc = pc; bus.i_start = 1'b1;
        bus.i_ld_we = ld_en; bus.i_ld_addr = ld_addr; bus.i_ld_data = ld_data;
        tick();
        bus.i_start = 1'b0; bus.i_ld_we = 1'b0;
        chk("busy_after_start", bus.q_busy, 1);
        n = 0; seen = 0;
        while (!seen && n < 10) begin
            tick();
            n++;
            if (n == 1) begin
                chk("sela", bus.q_sela, e.sela);
                chk("selb", bus.q_selb, e.selb);
                if (poke) begin
                    bus.i_start = 1'b1; bus.i_pc = 16'h0060;
                    bus.i_ld_we = 1'b1; bus.i_ld_addr = 8'h51; bus.i_ld_data = 16'h1134;
                end
            end
            if (n == 2) begin bus.i_start = 1'b0; bus.i_ld_we = 1'b0; end
            if (bus.q_done) seen = 1;
        end
        chk("done_seen", seen, 1);
        chk("latency", n, e.lat);
        chk("wb_en", bus.q_wb_en, e.wb_en);
        if (e.wb_en) begin
            chk("wb_sel", bus.q_wb_sel, e.wb_sel);
            chk("wb_data", bus.q_wb_data, e.wb_data);
        end
        chk("should_branch", bus.q_should_branch, e.br);
        chk("next_pc", bus.q_next_pc, e.npc);
        chk("flags", bus.q_flags, e.flags);
        chk("busy_at_done", bus.q_busy, 0);
        if (e.wb_en) regs[e.wb_sel] = e.wb_data;
        tick();
        chk("done_one_cycle", bus.q_done, 0);
        chk("wb_en_one_cycle", bus.q_wb_en, 0);
    endtask

    vec_t tbl[21];
    vec_t nov;

    initial begin
        int seen_done;
        tbl[0]  = '{16'h1134, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0034, 1'b0, 16'h0001, 3'b000};
        tbl[1]  = '{16'h1940, 16'h0001, 16'hFFFF, 16'h0002, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0002, 3'b000};
        tbl[2]  = '{16'h2380, 16'h0002, 16'h0005, 16'h0007, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'h0003, 3'b000};
        tbl[3]  = '{16'h2AF0, 16'h0003, 16'hFF20, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0004, 3'b000};
        tbl[4]  = '{16'h3140, 16'h0004, 16'hF0F0, 16'h3C3C, 16'h0000, 1'b1, 16'h3030, 1'b0, 16'h0005, 3'b000};
        tbl[5]  = '{16'h3940, 16'h0005, 16'hF0F0, 16'h3C3C, 16'h0000, 1'b1, 16'hFCFC, 1'b0, 16'h0006, 3'b000};
        tbl[6]  = '{16'h4140, 16'h0006, 16'hF0F0, 16'h3C3C, 16'h0000, 1'b1, 16'hCCCC, 1'b0, 16'h0007, 3'b000};
        tbl[7]  = '{16'h4DC3, 16'h0007, 16'h0000, 16'h8421, 16'h0000, 1'b1, 16'h2108, 1'b0, 16'h0008, 3'b000};
        tbl[8]  = '{16'h4DD4, 16'h0008, 16'h0000, 16'h8421, 16'h0000, 1'b1, 16'h0842, 1'b0, 16'h0009, 3'b000};
        tbl[9]  = '{16'h0F00, 16'h0009, 16'h0000, 16'h1234, 16'h1234, 1'b1, 16'h1234, 1'b0, 16'h000A, 3'b000};
        tbl[10] = '{16'h5070, 16'h000A, 16'h0000, 16'h8000, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h000B, 3'b100};
        tbl[11] = '{16'h8020, 16'h000B, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0020, 3'b100};
        tbl[12] = '{16'h7040, 16'h000C, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h000D, 3'b100};
        tbl[13] = '{16'h5070, 16'h000D, 16'h0000, 16'h0055, 16'h0055, 1'b0, 16'h0000, 1'b0, 16'h000E, 3'b001};
        tbl[14] = '{16'h7040, 16'h000E, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0040, 3'b001};
        tbl[15] = '{16'h7840, 16'h000F, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0010, 3'b001};
        tbl[16] = '{16'h5070, 16'h0010, 16'h0000, 16'h0001, 16'h8000, 1'b0, 16'h0000, 1'b0, 16'h0011, 3'b010};
        tbl[17] = '{16'h68AB, 16'h0011, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h00AB, 3'b010};
        tbl[18] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'b010};
        tbl[19] = '{16'hF800, 16'h0012, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0013, 3'b010};
        tbl[20] = '{16'h8020, 16'h0013, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0014, 3'b010};
        nov = tbl[0];

        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        mdl_flags = 3'b000;
        bus.i_start = 1'b0; bus.i_pc = 16'h0000;
        bus.i_ld_we = 1'b0; bus.i_ld_addr = 8'h00; bus.i_ld_data = 16'h0000;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        cur_tag = "reset";
        chk("rst_busy", bus.q_busy, 0);
        chk("rst_done", bus.q_done, 0);
        chk("rst_wb_en", bus.q_wb_en, 0);
        chk("rst_next_pc", bus.q_next_pc, 0);
        chk("rst_flags", bus.q_flags, 0);
        chk("rst_sela", bus.q_sela, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 256; i++) load(8'(i), 16'($urandom));

        // Directed table
        for (int i = 0; i < 21; i++) begin
            load(tbl[i].pc[7:0], tbl[i].instr);
            regs[tbl[i].instr[10:8]] = tbl[i].dv;
            regs[tbl[i].instr[7:5]]  = tbl[i].av;
            regs[tbl[i].instr[4:2]]  = tbl[i].bv;
            run(tbl[i].pc, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, tbl[i]);
        end

        // Store then load through the same effective address
        regs[2] = 16'hBEEF;
        load(8'h30, 16'h625F);
        load(8'h31, 16'h5E5F);
        run(16'h0030, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, nov);
        run(16'h0031, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, nov);

        // Reset during EXEC of a store must abort it
        regs[1] = 16'h1111; regs[3] = 16'h0080;
        load(8'h40, 16'h6160);
        run(16'h0040, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, nov);
        regs[1] = 16'h2222;
        load(8'h41, 16'h6160);
        cur_tag = "reset_abort";
        bus.i_pc = 16'h0041; bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.q_busy, 0);
        chk("abort_done", bus.q_done, 0);
        chk("abort_flags", bus.q_flags, 0);
        tick();
        rst = 1'b0;
        mdl_flags = 3'b000;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.q_done || bus.q_busy) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        load(8'h42, 16'h5C60);
        run(16'h0042, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, nov);

        // Start and program-load while busy are ignored; opcode 0x1F is a NOP
        load(8'h51, 16'h0000);
        load(8'h50, 16'hF800);
        run(16'h0050, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, nov);
        cur_tag = "busy_ignore";
        tick();
        chk("no_restart", bus.q_busy, 0);
        run(16'h0051, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, nov);

        // Program-load to the fetched address in the accept cycle: fetch sees old word
        load(8'h70, 16'h1111);
        run(16'h0070, 1'b1, 8'h70, 16'h1122, 1'b0, 1'b0, nov);
        run(16'h0070, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, nov);

        // Random instructions against the model
        for (int k = 0; k < 200; k++) begin
            logic [15:0] instr, pc;
            if ((k % 4) == 0) for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
            instr = {5'($urandom_range(0, 19)), 11'($urandom)};
            if ((k % 7) == 0) instr[15:11] = 5'($urandom_range(17, 31));
            pc = 16'($urandom);
            load(pc[7:0], instr);
            run(pc, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, nov);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
